// File: rtl/max7219_matrix_checker.sv
// Receiver model of a daisy chain of MAX7219 LED-matrix drivers: samples the
// 3-wire serial bus, decodes each latched frame into per-device registers and muxes one device out.
module max7219_matrix_checker #(
  parameter int G_NB_MATRIX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_max7219_clk,
  input  logic        i_max7219_din,
  input  logic        i_max7219_load,
  input  logic [7:0]  i_display_reg_matrix_n,
  input  logic        i_display_screen_matrix,
  output logic [63:0] o_rows,
  output logic [7:0]  o_decode_mode,
  output logic [3:0]  o_intensity,
  output logic [2:0]  o_scan_limit,
  output logic        o_shutdown,
  output logic        o_display_test,
  output logic [15:0] o_load_cnt,
  output logic        o_frame_err
);

  localparam int N  = 16 * G_NB_MATRIX;
  localparam int CW = $clog2(N + 2);
  localparam int IW = (G_NB_MATRIX > 1) ? $clog2(G_NB_MATRIX) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(N);
  localparam logic [CW-1:0] SAT_CNT  = CW'(N + 1);

  // Sample pipeline, bit order {load, din, clk}
  logic [2:0] s1, s2, s3;
  logic       clk_rise, load_rise;

  logic [N-1:0]  chain, chain_next;
  logic [CW-1:0] bit_cnt, bit_cnt_next;
  logic          frame_ok;

  logic [7:0] rows_q      [G_NB_MATRIX][8];
  logic [7:0] decode_q    [G_NB_MATRIX];
  logic [3:0] intensity_q [G_NB_MATRIX];
  logic [2:0] scan_q      [G_NB_MATRIX];
  logic       shutdown_q  [G_NB_MATRIX];
  logic       test_q      [G_NB_MATRIX];

  logic [3:0] addr_w [G_NB_MATRIX];
  logic [7:0] data_w [G_NB_MATRIX];
  logic [G_NB_MATRIX-1:0] nibble_unused;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= {i_max7219_load, i_max7219_din, i_max7219_clk};
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign clk_rise  = s2[0] & ~s3[0];
  assign load_rise = s2[2] & ~s3[2];

  // The shift is resolved first so a load in the same cycle sees the new bit.
  always_comb begin
    chain_next   = chain;
    bit_cnt_next = bit_cnt;
    if (clk_rise) begin
      chain_next = {chain[N-2:0], s2[1]};
      if (bit_cnt != SAT_CNT) bit_cnt_next = bit_cnt + 1'b1;
    end
  end

  assign frame_ok = (bit_cnt_next == FULL_CNT);

  for (genvar k = 0; k < G_NB_MATRIX; k++) begin : g_word
    assign addr_w[k]        = chain_next[16*k+8 +: 4];
    assign data_w[k]        = chain_next[16*k +: 8];
    assign nibble_unused[k] = ^chain_next[16*k+12 +: 4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain       <= '0;
      bit_cnt     <= '0;
      o_load_cnt  <= '0;
      o_frame_err <= 1'b0;
      for (int k = 0; k < G_NB_MATRIX; k++) begin
        for (int r = 0; r < 8; r++) rows_q[k][r] <= '0;
        decode_q[k]    <= '0;
        intensity_q[k] <= '0;
        scan_q[k]      <= '0;
        shutdown_q[k]  <= 1'b0;
        test_q[k]      <= 1'b0;
      end
    end else begin
      chain <= chain_next;
      if (load_rise) begin
        bit_cnt    <= '0;
        o_load_cnt <= o_load_cnt + 16'd1;
        if (!frame_ok) begin
          o_frame_err <= 1'b1;
        end else begin
          for (int k = 0; k < G_NB_MATRIX; k++) begin
            case (addr_w[k])
              4'h1, 4'h2, 4'h3, 4'h4,
              4'h5, 4'h6, 4'h7, 4'h8: rows_q[k][addr_w[k][2:0] - 3'd1] <= data_w[k];
              4'h9:    decode_q[k]    <= data_w[k];
              4'hA:    intensity_q[k] <= data_w[k][3:0];
              4'hB:    scan_q[k]      <= data_w[k][2:0];
              4'hC:    shutdown_q[k]  <= data_w[k][0];
              4'hF:    test_q[k]      <= data_w[k][0];
              default: ;
            endcase
          end
        end
      end else begin
        bit_cnt <= bit_cnt_next;
      end
    end
  end

  logic          sel_valid;
  logic [IW-1:0] sel;

  assign sel_valid = (i_display_reg_matrix_n < 8'(G_NB_MATRIX));
  assign sel       = i_display_reg_matrix_n[IW-1:0];

  always_comb begin
    o_rows         = '0;
    o_decode_mode  = '0;
    o_intensity    = '0;
    o_scan_limit   = '0;
    o_shutdown     = 1'b0;
    o_display_test = 1'b0;
    if (sel_valid) begin
      for (int r = 0; r < 8; r++) o_rows[8*r +: 8] = rows_q[sel][r];
      o_decode_mode  = decode_q[sel];
      o_intensity    = intensity_q[sel];
      o_scan_limit   = scan_q[sel];
      o_shutdown     = shutdown_q[sel];
      o_display_test = test_q[sel];
    end
  end

  // Screen printing is a simulator-side feature; nothing here consumes these bits.
  logic unused_bits;
  assign unused_bits = ^{s3[1], nibble_unused, i_display_screen_matrix};

endmodule

// File: tb/tb_max7219_matrix_checker.sv
// Randomized bench for max7219_matrix_checker against a word-level model of
// the MAX7219 chain (bit queue per frame, register array per device).
module tb_max7219_matrix_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mclk = 1'b0;
  logic        din = 1'b0;
  logic        load = 1'b0;
  logic [7:0]  sel_n = 8'd0;
  logic        screen = 1'b0;
  logic [63:0] o_rows;
  logic [7:0]  o_decode_mode;
  logic [3:0]  o_intensity;
  logic [2:0]  o_scan_limit;
  logic        o_shutdown;
  logic        o_display_test;
  logic [15:0] o_load_cnt;
  logic        o_frame_err;

  max7219_matrix_checker #(.G_NB_MATRIX(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_max7219_clk(mclk),
    .i_max7219_din(din),
    .i_max7219_load(load),
    .i_display_reg_matrix_n(sel_n),
    .i_display_screen_matrix(screen),
    .o_rows(o_rows),
    .o_decode_mode(o_decode_mode),
    .o_intensity(o_intensity),
    .o_scan_limit(o_scan_limit),
    .o_shutdown(o_shutdown),
    .o_display_test(o_display_test),
    .o_load_cnt(o_load_cnt),
    .o_frame_err(o_frame_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int failures = 0;

  // reference model
  logic [7:0]  m_regs [8][16];
  int          m_load_cnt;
  bit          m_err;
  bit          bit_q[$];
  logic [15:0] frame_w [8];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 8; k++)
      for (int a = 0; a < 16; a++) m_regs[k][a] = 8'h00;
    m_load_cnt = 0;
    m_err = 1'b0;
    bit_q.delete();
  endtask

  task automatic model_load();
    logic [15:0] w;
    m_load_cnt++;
    if (bit_q.size() != 128) begin
      m_err = 1'b1;
    end else begin
      for (int k = 0; k < 8; k++) begin
        w = '0;
        for (int i = 0; i < 16; i++) w = {w[14:0], bit_q[128 - 16*(k+1) + i]};
        if (w[11:8] != 4'h0 && w[11:8] != 4'hD && w[11:8] != 4'hE)
          m_regs[k][w[11:8]] = w[7:0];
      end
    end
    bit_q.delete();
  endtask

  // driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input bit b);
    din = b;
    wait_clk(2);
    mclk = 1'b1;
    bit_q.push_back(b);
    wait_clk(2);
    mclk = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_bit(w[i]);
  endtask

  // Device 7 goes out first so that device 0 ends up with the last word.
  task automatic send_frame();
    for (int k = 7; k >= 0; k--) send_word(frame_w[k]);
  endtask

  task automatic do_load();
    load = 1'b1;
    wait_clk(2);
    load = 1'b0;
    wait_clk(2);
    model_load();
    wait_clk(2);
  endtask

  task automatic frame_all(input logic [15:0] w);
    for (int k = 0; k < 8; k++) frame_w[k] = w;
    send_frame();
    do_load();
  endtask

  task automatic check_dev(input int idx);
    logic [63:0] er;
    sel_n = 8'(idx);
    #1;
    er = '0;
    if (idx < 8) for (int r = 0; r < 8; r++) er[8*r +: 8] = m_regs[idx][r+1];
    check_eq($sformatf("rows[%0d]", idx), o_rows, er);
    check_eq($sformatf("decode[%0d]", idx), 64'(o_decode_mode), 64'(idx < 8 ? m_regs[idx][9] : 8'h0));
    check_eq($sformatf("intensity[%0d]", idx), 64'(o_intensity), 64'(idx < 8 ? m_regs[idx][10][3:0] : 4'h0));
    check_eq($sformatf("scan[%0d]", idx), 64'(o_scan_limit), 64'(idx < 8 ? m_regs[idx][11][2:0] : 3'h0));
    check_eq($sformatf("shutdown[%0d]", idx), 64'(o_shutdown), 64'(idx < 8 ? m_regs[idx][12][0] : 1'b0));
    check_eq($sformatf("dtest[%0d]", idx), 64'(o_display_test), 64'(idx < 8 ? m_regs[idx][15][0] : 1'b0));
    check_eq("load_cnt", 64'(o_load_cnt), 64'(m_load_cnt[15:0]));
    check_eq("frame_err", 64'(o_frame_err), 64'(m_err));
  endtask

  task automatic check_all();
    for (int i = 0; i < 8; i++) check_dev(i);
    check_dev(8 + $urandom_range(0, 247));
  endtask

  // Rendered screen: '#' bits per row, device 0 in the leftmost byte.
  task automatic check_screen();
    logic [63:0] obs [8];
    logic [63:0] exp;
    for (int r = 0; r < 8; r++) obs[r] = '0;
    for (int d = 0; d < 8; d++) begin
      sel_n = 8'(d);
      #1;
      for (int r = 0; r < 8; r++)
        obs[r][63-8*d -: 8] = o_display_test ? 8'hFF : (o_shutdown ? o_rows[8*r +: 8] : 8'h00);
    end
    for (int r = 0; r < 8; r++) begin
      exp = '0;
      for (int d = 0; d < 8; d++)
        exp[63-8*d -: 8] = m_regs[d][15][0] ? 8'hFF : (m_regs[d][12][0] ? m_regs[d][r+1] : 8'h00);
      check_eq($sformatf("screen_row%0d", r), obs[r], exp);
    end
    screen = 1'b1;
    wait_clk(4);
    screen = 1'b0;
  endtask

  initial begin
    bit b;
    int nbits;
    model_reset();
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(3);
    check_all();

    // addr 1 = device index + 1
    for (int k = 0; k < 8; k++) frame_w[k] = 16'h0100 | 16'(k + 1);
    send_frame();
    do_load();
    sel_n = 8'd5;
    #1;
    check_eq("row1_dev5", 64'(o_rows[7:0]), 64'h06);
    check_all();

    // shutdown released on device 3 only
    for (int k = 0; k < 8; k++) frame_w[k] = 16'h0000;
    frame_w[3] = 16'h0C01;
    send_frame();
    do_load();
    check_all();

    // short frame then a good one
    for (int i = 0; i < 120; i++) send_bit(1'($urandom_range(0, 1)));
    do_load();
    check_all();
    frame_all(16'h0233);
    check_all();

    // overlong frame
    for (int i = 0; i < 136; i++) send_bit(1'($urandom_range(0, 1)));
    do_load();
    check_all();

    // serial clk and load rising in the same sampled cycle
    for (int i = 0; i < 127; i++) send_bit(1'($urandom_range(0, 1)));
    b = 1'($urandom_range(0, 1));
    din = b;
    wait_clk(2);
    mclk = 1'b1;
    load = 1'b1;
    bit_q.push_back(b);
    wait_clk(2);
    mclk = 1'b0;
    load = 1'b0;
    wait_clk(2);
    model_load();
    wait_clk(2);
    check_all();

    frame_all(16'h0A0F);
    frame_all(16'h0B07);
    frame_all(16'h0F01);
    check_all();
    check_screen();
    frame_all(16'h0F00);
    frame_all(16'h0C01);
    check_screen();

    // reset in the middle of a frame
    for (int i = 0; i < 64; i++) send_bit(1'($urandom_range(0, 1)));
    rst_n = 1'b0;
    wait_clk(2);
    model_reset();
    check_all();
    rst_n = 1'b1;
    wait_clk(2);
    frame_all(16'h0855);
    check_all();

    // randomized frames, mostly well formed
    for (int t = 0; t < 10; t++) begin
      nbits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(100, 150)) : 128;
      for (int i = 0; i < nbits; i++) send_bit(1'($urandom_range(0, 1)));
      do_load();
      check_all();
    end
    check_screen();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
